// File: rtl/vr_burst_source.sv
// Valid/ready burst generator: emits `len` incrementing beats from `seed` per start pulse.
// Optional inter-beat idle gap (gap port and GAP state) is enabled by defining VR_SOURCE_GAP_EN.
module vr_burst_source #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  input  logic [LEN_W-1:0] len,
`ifdef VR_SOURCE_GAP_EN
  input  logic [GAP_W-1:0] gap,
`endif
  output logic             busy,
  output logic             done,
  output logic             valid_out,
  output logic [WIDTH-1:0] data_out,
  output logic             last_out,
  input  logic             ready_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
`ifdef VR_SOURCE_GAP_EN
  localparam logic [1:0] S_GAP  = 2'd2;
`endif

  logic [1:0]       state;
  logic [WIDTH-1:0] data_q;
  logic [LEN_W-1:0] remaining;
  logic             done_q;
  logic             final_beat;

`ifdef VR_SOURCE_GAP_EN
  logic [GAP_W-1:0] gap_len;
  logic [GAP_W-1:0] gap_cnt;
`endif

  assign final_beat = (remaining == LEN_W'(1));

  // Every output below is a function of registers only, so ready_out never
  // reaches valid_out combinationally.
  assign valid_out = (state == S_SEND);
  assign data_out  = data_q;
  assign last_out  = valid_out && final_beat;
  assign busy      = (state != S_IDLE);
  assign done      = done_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; data_q is reset too because it drives data_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      data_q    <= '0;
      remaining <= '0;
      done_q    <= 1'b0;
`ifdef VR_SOURCE_GAP_EN
      gap_len   <= '0;
      gap_cnt   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (len != '0) begin
              data_q    <= seed;
              remaining <= len;
`ifdef VR_SOURCE_GAP_EN
              gap_len   <= gap;
`endif
              state     <= S_SEND;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        S_SEND: begin
          if (ready_out) begin
            data_q    <= data_q + 1'b1;
            remaining <= remaining - 1'b1;
            if (final_beat) begin
              state  <= S_IDLE;
              done_q <= 1'b1;
`ifdef VR_SOURCE_GAP_EN
            end else if (gap_len != '0) begin
              gap_cnt <= gap_len;
              state   <= S_GAP;
`endif
            end
          end
        end
`ifdef VR_SOURCE_GAP_EN
        S_GAP: begin
          // gap_cnt counts the idle cycles still to be spent, this one included.
          if (gap_cnt == GAP_W'(1)) state <= S_SEND;
          else                      gap_cnt <= gap_cnt - 1'b1;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vr_burst_source.sv
// Directed self-checking bench for vr_burst_source (WIDTH=8, LEN_W=8, GAP_W=4).
// Gap-mode vectors are compiled in only when VR_SOURCE_GAP_EN is defined.
module tb_vr_burst_source;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] seed = '0;
  logic [7:0] len = '0;
`ifdef VR_SOURCE_GAP_EN
  logic [3:0] gap = '0;
`endif
  logic       busy, done, valid_out, last_out;
  logic [7:0] data_out;
  logic       ready_out = 1'b1;

  int errors = 0;
  int checks = 0;

  vr_burst_source #(.WIDTH(8), .LEN_W(8), .GAP_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .seed      (seed),
    .len       (len),
`ifdef VR_SOURCE_GAP_EN
    .gap       (gap),
`endif
    .busy      (busy),
    .done      (done),
    .valid_out (valid_out),
    .data_out  (data_out),
    .last_out  (last_out),
    .ready_out (ready_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; outputs are then sampled and inputs driven 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the beat currently on the bus: valid, data, last, busy, done.
  task automatic beat(input string tag, input logic [7:0] d, input logic l);
    check({tag, ".valid"}, 32'(valid_out), 32'd1);
    check({tag, ".data"},  32'(data_out),  32'(d));
    check({tag, ".last"},  32'(last_out),  32'(l));
    check({tag, ".busy"},  32'(busy),      32'd1);
    check({tag, ".done"},  32'(done),      32'd0);
  endtask

  task automatic idle_done(input string tag, input logic d, input logic b);
    check({tag, ".valid"}, 32'(valid_out), 32'd0);
    check({tag, ".last"},  32'(last_out),  32'd0);
    check({tag, ".busy"},  32'(busy),      32'(b));
    check({tag, ".done"},  32'(done),      32'(d));
  endtask

  task automatic kick(input logic [7:0] s, input logic [7:0] n);
    start = 1'b1;
    seed  = s;
    len   = n;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int nbeats;
    int nlast;
    logic [7:0] last_data;

    // Reset state
    #12;
    idle_done("rst", 1'b0, 1'b0);
    check("rst.data", 32'(data_out), 32'h00);
    rst_n = 1'b1;
    tick();

    // 1. Asynchronous reset mid-burst, then a single-beat burst
    kick(8'h30, 8'd5);
    beat("mid0", 8'h30, 1'b0);
    tick();
    beat("mid1", 8'h31, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    idle_done("async_rst", 1'b0, 1'b0);
    check("async_rst.data", 32'(data_out), 32'h00);
    tick();
    rst_n = 1'b1;
    tick();
    kick(8'h00, 8'd1);
    beat("one", 8'h00, 1'b1);
    tick();
    idle_done("one_end", 1'b1, 1'b0);
    tick();
    idle_done("one_quiet", 1'b0, 1'b0);

    // 2. Basic burst, ready held high
    kick(8'h10, 8'd4);
    beat("b0", 8'h10, 1'b0);
    tick(); beat("b1", 8'h11, 1'b0);
    tick(); beat("b2", 8'h12, 1'b0);
    tick(); beat("b3", 8'h13, 1'b1);
    tick(); idle_done("b_done", 1'b1, 1'b0);
    tick(); idle_done("b_after", 1'b0, 1'b0);

    // 3. Backpressure while 0x11 is presented
    kick(8'h10, 8'd4);
    beat("bp0", 8'h10, 1'b0);
    tick();
    beat("bp1", 8'h11, 1'b0);
    ready_out = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      beat("bp_stall", 8'h11, 1'b0);
    end
    ready_out = 1'b1;
    tick(); beat("bp2", 8'h12, 1'b0);
    tick(); beat("bp3", 8'h13, 1'b1);
    tick(); idle_done("bp_done", 1'b1, 1'b0);
    tick();

    // 4. Wrap-around, start while busy ignored
    kick(8'hFE, 8'd3);
    beat("w0", 8'hFE, 1'b0);
    start = 1'b1; seed = 8'h55; len = 8'd7;
    tick();
    start = 1'b0;
    beat("w1", 8'hFF, 1'b0);
    tick(); beat("w2", 8'h00, 1'b1);
    tick(); idle_done("w_done", 1'b1, 1'b0);
    tick(); idle_done("w_ignored", 1'b0, 1'b0);

    // 5. Zero length
    kick(8'h77, 8'd0);
    idle_done("z_done", 1'b1, 1'b0);
    tick(); idle_done("z_after", 1'b0, 1'b0);

    // Back-to-back: start during the done cycle is accepted
    kick(8'h40, 8'd1);
    beat("bb0", 8'h40, 1'b1);
    tick();
    idle_done("bb_done", 1'b1, 1'b0);
    kick(8'h50, 8'd2);
    beat("bb1", 8'h50, 1'b0);
    tick(); beat("bb2", 8'h51, 1'b1);
    tick(); idle_done("bb_end", 1'b1, 1'b0);
    tick();

    // Maximum length burst (255 beats from 0x03, last beat 0x01)
    kick(8'h03, 8'hFF);
    nbeats = 0; nlast = 0; last_data = '0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (valid_out) begin
        nbeats++;
        if (last_out) begin
          nlast++;
          last_data = data_out;
        end
      end
      tick();
    end
    check("max.beats", 32'(nbeats), 32'd255);
    check("max.lasts", 32'(nlast), 32'd1);
    check("max.last_data", 32'(last_data), 32'h01);
    check("max.done", 32'(done), 32'd1);
    tick();

`ifdef VR_SOURCE_GAP_EN
    // 6. Gap mode: two idle cycles after each non-final beat
    gap = 4'd2;
    kick(8'h20, 8'd3);
    gap = 4'd0;
    beat("g0", 8'h20, 1'b0);
    tick(); idle_done("g0_idle0", 1'b0, 1'b1);
    tick(); idle_done("g0_idle1", 1'b0, 1'b1);
    tick(); beat("g1", 8'h21, 1'b0);
    tick(); idle_done("g1_idle0", 1'b0, 1'b1);
    tick(); idle_done("g1_idle1", 1'b0, 1'b1);
    tick(); beat("g2", 8'h22, 1'b1);
    tick(); idle_done("g_done", 1'b1, 1'b0);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
